// File: rtl/rail_monitor.sv
// rail_monitor: per-rail supervisor between the regulator monitor comparators
// and the PMIC status outputs. Synchronises and debounces voltageGood and
// currentGood, sequences the rail enable through a ramp window with timeout,
// and latches voltage/current faults until cleared with the rail disabled.
//
// Ports:
//   clk             system clock (4 MHz internal oscillator)
//   i_rst_n         asynchronous active-low reset
//   i_enable        sequencer request to turn the rail on
//   i_clearFault    request to clear latched faults (honoured only when disabled)
//   i_voltageGood   raw voltage-good, asynchronous, high = in regulation
//   i_currentGood   raw current monitor, asynchronous, high = within limit
//   o_railEnable    regulator enable
//   o_railGood      rail up and healthy
//   o_voltageFault  latched voltage fault
//   o_currentFault  latched overcurrent fault
//   o_state         FSM state code
//
// state | meaning
// ------+--------------------------------------------------------------
// OFF   | rail disabled, waiting for i_enable
// RAMP  | rail enabled, waiting for voltageGood within RAMP_TIMEOUT cycles
// GOOD  | rail up; any debounced monitor drop latches a fault
// FAULT | rail disabled, flags held until i_clearFault with i_enable low

module rail_monitor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RAMP_TIMEOUT    = 4000
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_clearFault,
    input  logic       i_voltageGood,
    input  logic       i_currentGood,
    output logic       o_railEnable,
    output logic       o_railGood,
    output logic       o_voltageFault,
    output logic       o_currentFault,
    output logic [1:0] o_state
);

    localparam int              TW      = (RAMP_TIMEOUT > 1) ? $clog2(RAMP_TIMEOUT) : 1;
    localparam logic [TW-1:0]   T_LAST  = TW'(RAMP_TIMEOUT - 1);
    localparam logic [7:0]      DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        GOOD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Bit 0 carries voltageGood, bit 1 carries currentGood.
    logic [1:0]    raw;
    logic [1:0]    sync_1;
    logic [1:0]    sync_2;
    logic [1:0]    deb;
    logic [7:0]    db_cnt [2];

    logic [TW-1:0] ramp_timer;
    state_t        state_q, state_d;
    logic          vfault_q, vfault_d;
    logic          cfault_q, cfault_d;

    logic          volt_ok;
    logic          curr_ok;
    logic          ramp_expired;

    assign raw = {i_currentGood, i_voltageGood};

    // Debounced currentGood resets to healthy so a rail is not faulted by the
    // synchroniser's reset value while it fills.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1    <= 2'b00;
            sync_2    <= 2'b00;
            deb       <= 2'b10;
            db_cnt[0] <= 8'd0;
            db_cnt[1] <= 8'd0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == deb[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_2[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign volt_ok = deb[0];
    assign curr_ok = deb[1];

    // Timer is held at zero outside RAMP, so every RAMP entry starts from zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ramp_timer <= '0;
        end else if (state_q == RAMP) begin
            if (ramp_timer != T_LAST) begin
                ramp_timer <= ramp_timer + 1'b1;
            end
        end else begin
            ramp_timer <= '0;
        end
    end

    assign ramp_expired = (ramp_timer == T_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= OFF;
            vfault_q <= 1'b0;
            cfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vfault_q <= vfault_d;
            cfault_q <= cfault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vfault_d = vfault_q;
        cfault_d = cfault_q;
        case (state_q)
            OFF: begin
                if (i_enable) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (!i_enable) begin
                    state_d = OFF;
                end else if (!curr_ok) begin
                    state_d  = FAULT;
                    cfault_d = 1'b1;
                    // A coincident timeout is reported too, unless voltage made it.
                    if (ramp_expired && !volt_ok) begin
                        vfault_d = 1'b1;
                    end
                end else if (volt_ok) begin
                    state_d = GOOD;
                end else if (ramp_expired) begin
                    state_d  = FAULT;
                    vfault_d = 1'b1;
                end
            end
            GOOD: begin
                if (!i_enable) begin
                    state_d = OFF;
                end else if (!curr_ok || !volt_ok) begin
                    state_d  = FAULT;
                    cfault_d = !curr_ok;
                    vfault_d = !volt_ok;
                end
            end
            FAULT: begin
                if (i_clearFault && !i_enable) begin
                    state_d  = OFF;
                    vfault_d = 1'b0;
                    cfault_d = 1'b0;
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign o_railEnable   = (state_q == RAMP) || (state_q == GOOD);
    assign o_railGood     = (state_q == GOOD);
    assign o_voltageFault = vfault_q;
    assign o_currentFault = cfault_q;
    assign o_state        = state_q;

endmodule

// File: doc/rail_monitor.md
Name: rail_monitor

Overview:
Per-rail supervisor that sits between the raw regulator monitor inputs (voltageGood/currentGood comparators) and the PMIC status/LED outputs. It synchronises and debounces both monitor signals, sequences the rail enable through a ramp window with timeout, and produces the railGood, voltageFault and currentFault indications consumed by the top level. The top level uses one instance per rail (12V, 3V3, 5V, 3V3ADC), all clocked from the 4 MHz internal oscillator.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required before a debounced input changes (1..255)
RAMP_TIMEOUT, 4000, RAMP-state cycles allowed for voltageGood to assert (1 ms at 4 MHz; 1..65535)

Ports:
clk  input  1  system clock (4 MHz internal oscillator)
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  sequencer request to turn the rail on (synchronous to clk)
i_clearFault  input  1  request to clear latched faults (synchronous to clk)
i_voltageGood  input  1  raw regulator voltage-good, asynchronous, high = in regulation
i_currentGood  input  1  raw current monitor, asynchronous, high = current within limit
o_railEnable  output  1  regulator enable
o_railGood  output  1  rail up and healthy
o_voltageFault  output  1  latched voltage fault
o_currentFault  output  1  latched overcurrent fault
o_state  output  2  FSM state: OFF=0, RAMP=1, GOOD=2, FAULT=3

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0: state=OFF, all outputs 0, fault flags 0, timers 0, synchroniser flops 0, debounced voltageGood=0, debounced currentGood=1 (healthy).
- Synchroniser: two flops per raw input; no logic between them.
- Debounce: a per-input counter increments while the synchronised value differs from the debounced value and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears. Raw edge to debounced change = 2 + DEBOUNCE_CYCLES clocks. Pulses shorter than DEBOUNCE_CYCLES synchronised cycles are rejected.
- FSM is Moore. Outputs are decoded from registered state and fault flags and change on the same edge as the state.
- OFF: railEnable=0, railGood=0. i_enable=1 -> RAMP with ramp timer cleared.
- RAMP: railEnable=1. Ramp timer increments each cycle. Priority, highest first:
  1. i_enable=0 -> OFF, no fault.
  2. Debounced currentGood=0 -> FAULT, set currentFault.
  3. Debounced voltageGood=1 -> GOOD.
  4. Timer = RAMP_TIMEOUT-1 -> FAULT, set voltageFault.
  If the current fault and the timeout occur in the same cycle, both flags are set. If voltageGood and the timeout occur in the same cycle, GOOD wins.
- GOOD: railEnable=1, railGood=1.
  - i_enable=0 -> OFF.
  - Otherwise, debounced currentGood=0 sets currentFault and debounced voltageGood=0 sets voltageFault. Either one -> FAULT. Both in the same cycle -> both flags set.
- FAULT: railEnable=0, railGood=0, flags held. Flags are not set again and are not cleared by the inputs recovering.
  - Exit only on i_clearFault=1 with i_enable=0 -> OFF, both flags cleared on that edge.
  - i_clearFault with i_enable=1 is ignored.
- i_clearFault in OFF, RAMP or GOOD has no effect.
- The ramp timer saturates; it never wraps. Its width is sized for RAMP_TIMEOUT.
- Reset asserted in any state forces the reset values immediately. Reset deassertion leaves the block in OFF; it does not re-enter RAMP until i_enable is sampled high.

Test Plan (DEBOUNCE_CYCLES=4, RAMP_TIMEOUT=20):
1. Normal power-up: reset release, i_enable=1, i_voltageGood rises 5 clocks later -> o_railEnable=1 one clock after enable is sampled; o_railGood=1 and o_state=2 exactly 7 clocks after the voltageGood edge (2 sync + 4 debounce + 1 FSM); no faults.
2. Glitch rejection: in GOOD, drive i_voltageGood low for 3 clocks -> o_railGood stays 1 and o_voltageFault stays 0; a low of 6 clocks -> o_voltageFault=1, o_state=3, o_railEnable=0.
3. Ramp timeout: i_enable=1 with i_voltageGood held 0 -> o_state=3 and o_voltageFault=1 on the 20th RAMP cycle; o_currentFault=0.
4. Overcurrent latch and clear: in GOOD, drop i_currentGood for 10 clocks -> o_currentFault=1; the flag stays set after currentGood returns. i_clearFault with i_enable=1 -> no change. i_enable=0 then i_clearFault -> o_state=0, both flags 0.
5. Disable during RAMP: i_enable drops at RAMP cycle 10 -> o_state=0, o_railEnable=0, no fault flags.
6. Async reset mid-GOOD: pulse i_rst_n low between clock edges -> all outputs 0 before the next edge; after release o_state=0 until i_enable is sampled high.
